router_local_port: RTL and testbench

//  Router-side endpoint of the core network interface (NI) link. Egress: pops 64-bit

---
 rtl/router_local_port_if.sv | 32 +++
 rtl/router_local_port.sv | 125 ++++++++++++
 tb/tb_router_local_port.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_local_port_if.sv
// Signal bundle between router_local_port and its surroundings: the NI FIFO pair
// and the two mesh valid/ready channels, all carrying {dest_core, payload} packets.
interface router_local_port_if;
  logic        ni_out_empty;
  logic [63:0] ni_out_data;
  logic        ni_out_rd;
  logic        ni_in_full;
  logic        ni_in_wr;
  logic [63:0] ni_in_data;
  logic        mesh_out_valid;
  logic        mesh_out_ready;
  logic [63:0] mesh_out_data;
  logic        mesh_in_valid;
  logic        mesh_in_ready;
  logic [63:0] mesh_in_data;

  // Router local port side.
  modport master (
    input  ni_out_empty, ni_out_data, ni_in_full,
    input  mesh_out_ready, mesh_in_valid, mesh_in_data,
    output ni_out_rd, ni_in_wr, ni_in_data,
    output mesh_out_valid, mesh_out_data, mesh_in_ready
  );

  // NI and mesh fabric side.
  modport slave (
    output ni_out_empty, ni_out_data, ni_in_full,
    output mesh_out_ready, mesh_in_valid, mesh_in_data,
    input  ni_out_rd, ni_in_wr, ni_in_data,
    input  mesh_out_valid, mesh_out_data, mesh_in_ready
  );
endinterface

// File: rtl/router_local_port.sv
// Router-side endpoint of the core NI link: NI outbound FIFO -> mesh egress, mesh ingress
// -> NI inbound FIFO. Define LOOPBACK_EN to turn packets addressed to LOCAL_ID back into the NI.
module router_local_port #(
  parameter logic [31:0] LOCAL_ID = 32'd0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  router_local_port_if.master port,
  output logic [CNT_W-1:0]    tx_count,
  output logic [CNT_W-1:0]    rx_count
);

  typedef enum logic [1:0] {
    E_IDLE,
    E_WAIT,
`ifdef LOOPBACK_EN
    E_SEND,
    E_LOOP
`else
    E_SEND
`endif
  } egress_state_e;

  egress_state_e    state_q, state_d;
  logic [63:0]      egress_q, egress_d;
  logic             ni_in_wr_q, ni_in_wr_d;
  logic [63:0]      ni_in_data_q, ni_in_data_d;
  logic [CNT_W-1:0] tx_count_q, rx_count_q;
  logic             run_q;
  logic             tx_inc;
  logic             loop_wr;
  logic             in_ready;
  logic             in_accept;

  // NOTE: every variable written here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    egress_d  = egress_q;
    tx_inc    = 1'b0;
    loop_wr   = 1'b0;
    port.ni_out_rd = 1'b0;
    case (state_q)
      E_IDLE: begin
        // run_q keeps the pop quiet until the first edge after reset release.
        if (run_q && !port.ni_out_empty) begin
          port.ni_out_rd = 1'b1;
          state_d        = E_WAIT;
        end
      end
      E_WAIT: begin
        egress_d = port.ni_out_data;
        state_d  = E_SEND;
`ifdef LOOPBACK_EN
        if (port.ni_out_data[63:32] == LOCAL_ID) state_d = E_LOOP;
`endif
      end
      E_SEND: begin
        if (port.mesh_out_ready) begin
          tx_inc  = 1'b1;
          state_d = E_IDLE;
        end
      end
`ifdef LOOPBACK_EN
      E_LOOP: begin
        if (!port.ni_in_full && !ni_in_wr_q) begin
          loop_wr = 1'b1;
          tx_inc  = 1'b1;
          state_d = E_IDLE;
        end
      end
`endif
      default: state_d = E_IDLE;
    endcase
  end

  // At most one NI write in flight, so full is always re-sampled before the next accept.
`ifdef LOOPBACK_EN
  assign in_ready = run_q && !port.ni_in_full && !ni_in_wr_q && (state_q != E_LOOP);
`else
  assign in_ready = run_q && !port.ni_in_full && !ni_in_wr_q;
`endif
  assign in_accept = port.mesh_in_valid && in_ready;

  always_comb begin
    ni_in_wr_d   = in_accept || loop_wr;
    ni_in_data_d = ni_in_data_q;
    if (loop_wr)        ni_in_data_d = egress_q;
    else if (in_accept) ni_in_data_d = port.mesh_in_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the packet registers are reset as well, not only the control state, so
      // the outputs read 0 during reset and a packet caught mid-flight is discarded.
      run_q        <= 1'b0;
      state_q      <= E_IDLE;
      egress_q     <= '0;
      ni_in_wr_q   <= 1'b0;
      ni_in_data_q <= '0;
      tx_count_q   <= '0;
      rx_count_q   <= '0;
    end else begin
      run_q        <= 1'b1;
      state_q      <= state_d;
      egress_q     <= egress_d;
      ni_in_wr_q   <= ni_in_wr_d;
      ni_in_data_q <= ni_in_data_d;
      if (tx_inc && (tx_count_q != '1))     tx_count_q <= tx_count_q + CNT_W'(1);
      if (ni_in_wr_d && (rx_count_q != '1)) rx_count_q <= rx_count_q + CNT_W'(1);
    end
  end

  assign port.mesh_out_valid = (state_q == E_SEND);
  assign port.mesh_out_data  = egress_q;
  assign port.mesh_in_ready  = in_ready;
  assign port.ni_in_wr       = ni_in_wr_q;
  assign port.ni_in_data     = ni_in_data_q;
  assign tx_count            = tx_count_q;
  assign rx_count            = rx_count_q;

endmodule

// File: tb/tb_router_local_port.sv
// Bench for router_local_port: NI FIFOs and mesh peers are modelled as packet queues;
// a second instance with 4-bit counters exercises counter saturation.
module tb_router_local_port;

  localparam logic [31:0] LOCAL_ID = 32'd5;
  localparam int CNT_W  = 16;
  localparam int CNT2_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [CNT_W-1:0]  tx_count, rx_count;
  logic [CNT2_W-1:0] tx_count2, rx_count2;

  router_local_port_if bus ();
  router_local_port_if bus2 ();

  router_local_port #(.LOCAL_ID(LOCAL_ID), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .port(bus), .tx_count(tx_count), .rx_count(rx_count)
  );

  router_local_port #(.LOCAL_ID(LOCAL_ID), .CNT_W(CNT2_W)) dut_sat (
    .clk(clk), .rst_n(rst_n), .port(bus2), .tx_count(tx_count2), .rx_count(rx_count2)
  );

  assign bus2.ni_out_empty   = bus.ni_out_empty;
  assign bus2.ni_out_data    = bus.ni_out_data;
  assign bus2.ni_in_full     = bus.ni_in_full;
  assign bus2.mesh_out_ready = bus.mesh_out_ready;
  assign bus2.mesh_in_valid  = bus.mesh_in_valid;
  assign bus2.mesh_in_data   = bus.mesh_in_data;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] out_q[$];   // NI outbound FIFO contents
  logic [63:0] in_src[$];  // packets the mesh still has to offer
  logic [63:0] got_tx[$];  // packets accepted on mesh_out
  logic [63:0] got_rx[$];  // packets written into the NI inbound FIFO
  logic [63:0] exp_tx[$];
  logic [63:0] exp_rx[$];

  bit pop_pend, acc_pend, wr_pend, prev_stall, manual_full, in_full_v;
  logic [63:0] prev_data;
  int cyc, rd_cnt, rd_cyc, valid_cyc, underflow, overflow, valid_drop, data_change;
  int in_rdy_cnt, in_occ, in_depth;
  int unsigned rdy_pct, in_pct, drain_pct;

  // One clock cycle of the environment: apply the edge just passed, drive, then observe.
  task automatic tick();
    bit keep;
    @(negedge clk);
    cyc++;
    if (pop_pend && out_q.size() > 0) bus.ni_out_data = out_q.pop_front();
    pop_pend = 1'b0;
    keep = bus.mesh_in_valid && !acc_pend;
    if (acc_pend) in_src.delete(0);
    acc_pend = 1'b0;
    if (wr_pend) in_occ++;
    wr_pend = 1'b0;
    if (in_occ > 0 && $urandom_range(99) < drain_pct) in_occ--;

    bus.ni_out_empty   = (out_q.size() == 0);
    bus.mesh_out_ready = ($urandom_range(99) < rdy_pct);
    if (!keep) begin
      bus.mesh_in_valid = (in_src.size() > 0) && ($urandom_range(99) < in_pct);
      bus.mesh_in_data  = bus.mesh_in_valid ? in_src[0] : {$urandom, $urandom};
    end
    bus.ni_in_full = manual_full ? in_full_v : (in_occ >= in_depth);
    #1;

    if (bus.ni_out_rd) begin
      rd_cnt++;
      if (rd_cyc < 0) rd_cyc = cyc;
      if (bus.ni_out_empty) underflow++;
      else pop_pend = 1'b1;
    end
    if (bus.mesh_out_valid && valid_cyc < 0) valid_cyc = cyc;
    if (prev_stall) begin
      if (!bus.mesh_out_valid) valid_drop++;
      else if (bus.mesh_out_data !== prev_data) data_change++;
    end
    if (bus.mesh_out_valid && bus.mesh_out_ready) got_tx.push_back(bus.mesh_out_data);
    prev_stall = bus.mesh_out_valid && !bus.mesh_out_ready;
    prev_data  = bus.mesh_out_data;
    if (bus.mesh_in_valid && bus.mesh_in_ready) acc_pend = 1'b1;
    if (bus.mesh_in_ready) in_rdy_cnt++;
    if (bus.ni_in_wr) begin
      got_rx.push_back(bus.ni_in_data);
      wr_pend = 1'b1;
      if (bus.ni_in_full) overflow++;
    end
  endtask

  task automatic clear_model();
    out_q.delete(); in_src.delete(); got_tx.delete(); got_rx.delete();
    exp_tx.delete(); exp_rx.delete();
    pop_pend = 0; acc_pend = 0; wr_pend = 0; prev_stall = 0; prev_data = '0;
    rd_cnt = 0; rd_cyc = -1; valid_cyc = -1; underflow = 0; overflow = 0;
    valid_drop = 0; data_change = 0; in_rdy_cnt = 0; in_occ = 0; cyc = 0;
    manual_full = 1; in_full_v = 0; in_depth = 4;
    rdy_pct = 100; in_pct = 100; drain_pct = 50;
    bus.ni_out_empty = 1'b1; bus.ni_out_data = '0; bus.ni_in_full = 1'b0;
    bus.mesh_out_ready = 1'b0; bus.mesh_in_valid = 1'b0; bus.mesh_in_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_until(input int n_tx, input int n_rx, input int budget,
                           output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (got_tx.size() >= n_tx && got_rx.size() >= n_rx) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_model();
    bus.ni_out_empty  = 1'b0;
    bus.mesh_in_valid = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.ni_out_rd !== 1'b0 || bus.ni_in_wr !== 1'b0 || bus.mesh_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: rd=%b wr=%b valid=%b, required all 0",
               bus.ni_out_rd, bus.ni_in_wr, bus.mesh_out_valid);
    end
    checks++;
    if (bus.mesh_out_data !== 64'd0 || bus.ni_in_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_data: mesh_out_data=%h ni_in_data=%h, required 0",
               bus.mesh_out_data, bus.ni_in_data);
    end
    checks++;
    if (bus.mesh_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 0", bus.mesh_in_ready);
    end
    checks++;
    if (tx_count !== '0 || rx_count !== '0) begin
      errors++;
      $display("FAIL reset_counts: tx=%0d rx=%0d, required 0", tx_count, rx_count);
    end
  endtask

  task automatic test_single();
    logic [63:0] pkt;
    bit to;
    do_reset();
    pkt = 64'h0000_0003_DEAD_BEEF;
    out_q.push_back(pkt);
    run_until(1, 0, 30, to);
    repeat (4) tick();
    checks++;
    if (to) begin
      errors++;
      $display("FAIL single_timeout: packet not delivered in 30 cycles");
    end
    checks++;
    if (rd_cnt != 1) begin
      errors++;
      $display("FAIL single_pop_count: got %0d pops, required 1", rd_cnt);
    end
    checks++;
    if (valid_cyc - rd_cyc != 2) begin
      errors++;
      $display("FAIL single_latency: got %0d cycles pop-to-valid, required 2", valid_cyc - rd_cyc);
    end
    checks++;
    if (got_tx.size() != 1 || got_tx[0] !== pkt) begin
      errors++;
      $display("FAIL single_data: got %0d pkts first %h, required 1 pkt %h",
               got_tx.size(), got_tx[0], pkt);
    end
    checks++;
    if (tx_count !== 16'd1 || tx_count2 !== 4'd1) begin
      errors++;
      $display("FAIL single_tx_count: got %0d/%0d, required 1/1", tx_count, tx_count2);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] p0, p1;
    bit to;
    do_reset();
    p0 = {$urandom, $urandom};
    p1 = {$urandom, $urandom};
`ifdef LOOPBACK_EN
    if (p0[63:32] == LOCAL_ID) p0[32] = ~p0[32];
    if (p1[63:32] == LOCAL_ID) p1[32] = ~p1[32];
`endif
    out_q.push_back(p0);
    out_q.push_back(p1);
    rdy_pct = 0;
    for (int i = 0; i < 20 && valid_cyc < 0; i++) tick();
    repeat (10) tick();
    checks++;
    if (bus.mesh_out_valid !== 1'b1 || bus.mesh_out_data !== p0) begin
      errors++;
      $display("FAIL stall_hold: valid=%b data=%h, required 1 %h", bus.mesh_out_valid,
               bus.mesh_out_data, p0);
    end
    checks++;
    if (valid_drop != 0 || data_change != 0) begin
      errors++;
      $display("FAIL stall_stable: valid drops %0d data changes %0d, required 0/0",
               valid_drop, data_change);
    end
    checks++;
    if (rd_cnt != 1 || got_tx.size() != 0) begin
      errors++;
      $display("FAIL stall_pops: got %0d pops %0d sent, required 1 pop 0 sent", rd_cnt, got_tx.size());
    end
    rdy_pct = 100;
    run_until(2, 0, 40, to);
    repeat (10) tick();
    checks++;
    if (to || got_tx.size() != 2 || got_tx[0] !== p0 || got_tx[1] !== p1) begin
      errors++;
      $display("FAIL stall_release: got %0d pkts (%h %h), required 2 (%h %h)",
               got_tx.size(), got_tx[0], got_tx[1], p0, p1);
    end
    checks++;
    if (rd_cnt != 2 || underflow != 0 || tx_count !== 16'd2) begin
      errors++;
      $display("FAIL stall_after_empty: pops %0d underflows %0d tx %0d, required 2 0 2",
               rd_cnt, underflow, tx_count);
    end
  endtask

  task automatic test_ingress_full();
    bit to;
    int mism;
    do_reset();
    for (int i = 0; i < 4; i++) exp_rx.push_back({$urandom, $urandom});
    in_src = exp_rx;
    run_until(0, 2, 30, to);
    in_full_v = 1'b1;
    in_rdy_cnt = 0;
    repeat (10) tick();
    checks++;
    if (to || got_rx.size() != 2 || in_rdy_cnt != 0) begin
      errors++;
      $display("FAIL full_holdoff: writes %0d ready cycles %0d, required 2 writes 0 ready",
               got_rx.size(), in_rdy_cnt);
    end
    in_full_v = 1'b0;
    run_until(0, 4, 30, to);
    repeat (3) tick();
    mism = 0;
    for (int i = 0; i < exp_rx.size(); i++)
      if (i >= got_rx.size() || got_rx[i] !== exp_rx[i]) mism++;
    checks++;
    if (to || got_rx.size() != 4 || mism != 0 || overflow != 0) begin
      errors++;
      $display("FAIL full_resume: writes %0d mismatches %0d overflows %0d, required 4 0 0",
               got_rx.size(), mism, overflow);
    end
    checks++;
    if (rx_count !== 16'd4 || rx_count2 !== 4'd4) begin
      errors++;
      $display("FAIL full_rx_count: got %0d/%0d, required 4/4", rx_count, rx_count2);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int mism_tx, mism_rx;
    logic [63:0] p;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      p = {$urandom, $urandom};
`ifdef LOOPBACK_EN
      if (p[63:32] == LOCAL_ID) p[32] = ~p[32];
`endif
      exp_tx.push_back(p);
      exp_rx.push_back({$urandom, $urandom});
    end
    out_q = exp_tx;
    in_src = exp_rx;
    manual_full = 1'b0;
    drain_pct = 60;
    rdy_pct = 85;
    in_pct = 90;
    run_until(100, 100, 5000, to);
    repeat (10) tick();
    mism_tx = 0;
    mism_rx = 0;
    for (int i = 0; i < 100; i++) begin
      if (i >= got_tx.size() || got_tx[i] !== exp_tx[i]) mism_tx++;
      if (i >= got_rx.size() || got_rx[i] !== exp_rx[i]) mism_rx++;
    end
    checks++;
    if (to || got_tx.size() != 100 || mism_tx != 0) begin
      errors++;
      $display("FAIL b2b_egress: got %0d pkts %0d mismatches, required 100 0", got_tx.size(), mism_tx);
    end
    checks++;
    if (to || got_rx.size() != 100 || mism_rx != 0) begin
      errors++;
      $display("FAIL b2b_ingress: got %0d pkts %0d mismatches, required 100 0", got_rx.size(), mism_rx);
    end
    checks++;
    if (tx_count !== 16'd100 || rx_count !== 16'd100) begin
      errors++;
      $display("FAIL b2b_counts: tx=%0d rx=%0d, required 100/100", tx_count, rx_count);
    end
    checks++;
    if (tx_count2 !== 4'hF || rx_count2 !== 4'hF) begin
      errors++;
      $display("FAIL b2b_saturate: tx=%0d rx=%0d, required 15/15", tx_count2, rx_count2);
    end
    checks++;
    if (underflow != 0 || overflow != 0 || valid_drop != 0 || data_change != 0) begin
      errors++;
      $display("FAIL b2b_protocol: underflow %0d overflow %0d drops %0d changes %0d, required 0",
               underflow, overflow, valid_drop, data_change);
    end
  endtask

  task automatic test_loopback();
    logic [63:0] lp, m0, m1;
    bit to;
    do_reset();
    lp = 64'h0000_0005_0000_0001;
    m0 = {$urandom, $urandom};
    m1 = {$urandom, $urandom};
    out_q.push_back(lp);
    in_src.push_back(m0);
    in_src.push_back(m1);
`ifdef LOOPBACK_EN
    run_until(0, 3, 40, to);
    repeat (5) tick();
    checks++;
    if (to || got_tx.size() != 0 || got_rx.size() != 3) begin
      errors++;
      $display("FAIL loop_route: mesh_out %0d writes %0d, required 0 and 3", got_tx.size(), got_rx.size());
    end
    checks++;
    if (got_rx[0] !== m0 || got_rx[1] !== lp || got_rx[2] !== m1) begin
      errors++;
      $display("FAIL loop_order: got %h %h %h, required %h %h %h",
               got_rx[0], got_rx[1], got_rx[2], m0, lp, m1);
    end
    checks++;
    if (tx_count !== 16'd1 || rx_count !== 16'd3) begin
      errors++;
      $display("FAIL loop_counts: tx=%0d rx=%0d, required 1/3", tx_count, rx_count);
    end
`else
    run_until(1, 2, 40, to);
    repeat (5) tick();
    checks++;
    if (to || got_tx.size() != 1 || got_tx[0] !== lp) begin
      errors++;
      $display("FAIL local_dest_egress: got %0d pkts first %h, required 1 %h",
               got_tx.size(), got_tx[0], lp);
    end
    checks++;
    if (got_rx.size() != 2 || got_rx[0] !== m0 || got_rx[1] !== m1) begin
      errors++;
      $display("FAIL local_dest_ingress: got %0d writes, required 2 in order", got_rx.size());
    end
    checks++;
    if (tx_count !== 16'd1 || rx_count !== 16'd2) begin
      errors++;
      $display("FAIL local_dest_counts: tx=%0d rx=%0d, required 1/2", tx_count, rx_count);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [63:0] p0, p1;
    bit to;
    do_reset();
    p0 = 64'h0000_0007_1234_5678;
    p1 = 64'h0000_0009_CAFE_F00D;
    out_q.push_back(p0);
    rdy_pct = 0;
    for (int i = 0; i < 20 && valid_cyc < 0; i++) tick();
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mesh_out_valid !== 1'b0 || bus.mesh_out_data !== 64'd0 || bus.ni_out_rd !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: valid=%b data=%h rd=%b, required 0",
               bus.mesh_out_valid, bus.mesh_out_data, bus.ni_out_rd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    prev_stall = 1'b0;
    pop_pend = 1'b0;
    rdy_pct = 100;
    repeat (10) tick();
    checks++;
    if (got_tx.size() != 0 || rd_cnt != 1 || tx_count !== 16'd0) begin
      errors++;
      $display("FAIL midreset_drop: sent %0d pops %0d tx %0d, required 0 1 0",
               got_tx.size(), rd_cnt, tx_count);
    end
    out_q.push_back(p1);
    run_until(1, 0, 30, to);
    repeat (2) tick();
    checks++;
    if (to || got_tx.size() != 1 || got_tx[0] !== p1 || tx_count !== 16'd1) begin
      errors++;
      $display("FAIL midreset_recover: sent %0d first %h tx %0d, required 1 %h 1",
               got_tx.size(), got_tx[0], tx_count, p1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_model();
    test_reset();
    test_single();
    test_backpressure();
    test_ingress_full();
    test_back_to_back();
    test_loopback();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
